// File: rtl/acc_delay_line.sv
// Run-time selectable, stallable delay line aligning accumulator partial sums with the other operands.
// Optional macro ACC_DELAY_CNT_EN exposes the in-flight beat count on the inflight port.
module acc_delay_line #(
    parameter int PIC_NUM        = 8,
    parameter int WIDTH_DATA_OUT = 16,
    parameter int DATA_W         = PIC_NUM * WIDTH_DATA_OUT * 2,
    parameter int MAX_DEPTH      = 16,
    parameter int DEFAULT_DELAY  = 6,
    parameter int DSEL_W         = $clog2(MAX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [DSEL_W-1:0] delay_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [DSEL_W-1:0] delay_cur
`ifdef ACC_DELAY_CNT_EN
    ,
    output logic [DSEL_W-1:0] inflight
`endif
);

    localparam logic [DSEL_W-1:0] DEFAULT_SEL = DSEL_W'((DEFAULT_DELAY < 32'sd1) ? 32'sd1 :
                                                ((DEFAULT_DELAY > MAX_DEPTH) ? MAX_DEPTH : DEFAULT_DELAY));

    // Map a requested delay onto the physically available range 1..MAX_DEPTH.
    function automatic logic [DSEL_W-1:0] clamp_delay(input logic [DSEL_W-1:0] sel);
        logic [DSEL_W-1:0] res;
        if (sel == {DSEL_W{1'b0}}) begin
            res = DSEL_W'(32'd1);
        end else if (int'(sel) > MAX_DEPTH) begin
            res = DSEL_W'(MAX_DEPTH);
        end else begin
            res = sel;
        end
        return res;
    endfunction

    logic [DATA_W-1:0] d_r [1:MAX_DEPTH];
    logic              v_r [1:MAX_DEPTH];
    logic [DSEL_W-1:0] count_r;
    logic [DSEL_W-1:0] delay_cur_r;
    logic [DSEL_W-1:0] count_nxt_s;
    logic [DATA_W-1:0] out_data_s;
    logic              out_valid_s;

    // Active tap select: a mux over stage registers only.
    always_comb begin
        out_data_s  = {DATA_W{1'b0}};
        out_valid_s = 1'b0;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (DSEL_W'(k) == delay_cur_r) begin
                out_data_s  = d_r[k];
                out_valid_s = v_r[k];
            end else begin
                out_data_s  = out_data_s;
                out_valid_s = out_valid_s;
            end
        end
    end

    // In-flight count: one in at stage 1, one out at the active tap; both together cancel.
    always_comb begin
        count_nxt_s = count_r;
        if (in_valid && !out_valid_s) begin
            count_nxt_s = count_r + DSEL_W'(32'd1);
        end else if (!in_valid && out_valid_s) begin
            count_nxt_s = count_r - DSEL_W'(32'd1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Stage shift, valid masking beyond the tap, count and delay bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                d_r[k] <= {DATA_W{1'b0}};
                v_r[k] <= 1'b0;
            end
            count_r     <= {DSEL_W{1'b0}};
            delay_cur_r <= DEFAULT_SEL;
        end else if (flush) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                v_r[k] <= 1'b0;
            end
            count_r <= {DSEL_W{1'b0}};
        end else begin
            // Delay may only move when nothing is in flight, so no beat sees two taps.
            if (count_r == {DSEL_W{1'b0}}) begin
                delay_cur_r <= clamp_delay(delay_sel);
            end
            if (en) begin
                d_r[1] <= in_data;
                v_r[1] <= in_valid;
                for (int k = 2; k <= MAX_DEPTH; k++) begin
                    d_r[k] <= d_r[k-1];
                    v_r[k] <= v_r[k-1] & (DSEL_W'(k) <= delay_cur_r);
                end
                count_r <= count_nxt_s;
            end
        end
    end

    assign out_data  = out_data_s;
    assign out_valid = out_valid_s;
    assign busy      = (count_r != {DSEL_W{1'b0}});
    assign delay_cur = delay_cur_r;

`ifdef ACC_DELAY_CNT_EN
    assign inflight = count_r;
`else
    // count_r remains internal, still driving busy and the delay-load rule.
`endif

endmodule

// File: doc/acc_delay_line.md
# acc_delay_line

Parametrised, stallable delay line that aligns accumulator partial sums with the other operands of the convolution datapath. The delay can be selected at run time, from 1 to MAX_DEPTH enabled cycles. Each beat carries a valid flag. The block supports pipeline stall and synchronous flush, and tracks how many beats are in flight so that a delay change can never corrupt or duplicate data. It sits between the per-channel MAC/adder tree and the cross-channel accumulator.

## Interface
- PIC_NUM, 8, pictures processed in parallel
- WIDTH_DATA_OUT, 16, width of one partial-sum lane
- DATA_W, PIC_NUM*WIDTH_DATA_OUT*2, data bus width
- MAX_DEPTH, 16, number of physical stages; maximum delay
- DEFAULT_DELAY, 6, delay loaded at reset
- DSEL_W, $clog2(MAX_DEPTH+1), width of the delay fields

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance the pipeline; when low, all state holds
- flush  in  1  synchronous clear of in-flight beats; takes priority over en
- delay_sel  in  DSEL_W  requested delay in enabled cycles
- in_valid  in  1  in_data is a real beat
- in_data  in  DATA_W  input partial sums
- out_valid  out  1  valid flag at the active tap
- out_data  out  DATA_W  data at the active tap
- busy  out  1  in-flight count is non-zero
- delay_cur  out  DSEL_W  currently active delay
- inflight  out  DSEL_W  in-flight count; present only under ACC_DELAY_CNT_EN

## Operation
- **Storage:**
  - Stages 1..MAX_DEPTH, each holding a data register d[k] and a valid bit v[k].
  - out_data = d[delay_cur], out_valid = v[delay_cur]. This is a mux over registers, so there is no combinational path from the inputs to the outputs.
- **Enabled edge (en=1, flush=0):**
  - d[1]<=in_data, v[1]<=in_valid.
  - For k≥2: d[k]<=d[k-1], v[k]<=v[k-1] & (k≤delay_cur).
  - Data registers shift regardless of valid.
- **Invariant:** v[k]=0 for every k>delay_cur.
- **Count update:** count <= count + (en&in_valid) − (en&out_valid).
  - If both terms are 1 in the same cycle, count is unchanged.
  - count never exceeds delay_cur, so no overflow is possible.
- **Delay update:**
  - delay_cur <= clamp(delay_sel) on every edge where count==0 (current value).
  - clamp: 0 maps to 1; values above MAX_DEPTH map to MAX_DEPTH.
  - While count≠0, delay_cur holds and changes on delay_sel are ignored.
  - A beat accepted on the same edge that loads a new delay travels with the new delay.
- **Flush:**
  - On the flush edge: all v<=0 and count<=0. delay_cur does not load on this edge.
  - A beat presented with in_valid during flush is dropped.
  - d[k] are not cleared.
- **en=0, flush=0:** d, v and count hold. delay_cur may still load if count==0.

## Timing
- **Reset (asynchronous, immediate on rst_n low):**
  - d and v go to 0, count=0, delay_cur=clamp(DEFAULT_DELAY).
  - Output values during reset: out_data=0, out_valid=0, busy=0, inflight=0.
- **Latency with en held high:** a beat presented in cycle 0 (captured at edge 1) appears on out_data/out_valid during cycle delay_cur (after edge delay_cur).
  - With the default delay of 6, the beat appears after edge 6.
- **Latency with stalls:** latency counts enabled edges only. Each cycle with en=0 adds one cycle of latency to every in-flight beat.
- **Throughput:** one beat per enabled cycle with no bubbles. Ordering is preserved and there is no loss or duplication.
- **Flush:** out_valid and busy are low in the cycle after the flush edge.
- **Reset mid-stream:** all in-flight beats are lost. Operation resumes with DEFAULT_DELAY.

## Configuration
- Macro: ACC_DELAY_CNT_EN.
- **Defined:** the inflight output port exists and carries count.
- **Undefined:** the port is absent. count is still maintained internally and drives busy and the delay-update rule. Behaviour is otherwise identical.

## Test plan
- **Basic stream:** reset, delay_sel=6, en=1, in_data=1..10 with in_valid high in cycles 0–9 -> out_valid high in cycles 6–15, out_data 1..10 in order, busy high from cycle 1 through cycle 15.
- **Stall:** en=0 for cycles 3–5 during the same stream -> outputs and count hold during the stall; beats land 3 cycles later; no loss or duplication.
- **Delay change while busy:** delay_sel changes 6→3 at cycle 2 while beats are in flight -> delay_cur stays 6 until count reaches 0, then becomes 3; the next beat emerges after 3 edges; no stale valid appears.
- **Flush:** 4 beats in flight, flush=1 with in_valid=1 -> the next cycle shows out_valid=0, busy=0, inflight=0; none of the 5 beats ever appears on the output.
- **Clamping:** delay_sel=0 -> delay_cur=1 and latency is 1 edge; delay_sel=31 -> delay_cur=16 and latency is 16 edges.
- **Asynchronous reset:** rst_n low mid-stream, between clock edges -> all outputs are 0 immediately and delay_cur=6; the stream restarts cleanly after rst_n is released.
